// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: default width, RV32I size codes, FSM encoding.
package dmem_responder_pkg;

    localparam int unsigned WORD_SIZE_DEF = 32;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_responder_load_store_align.sv
// Byte-lane steering: store write mask/data placement and load lane select with extension.
module load_store_align
    import dmem_responder_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF
) (
    input  logic [2:0]             i_funct3,
    input  logic [1:0]             i_byte_off,
    input  logic [WORD_SIZE-1:0]   i_wdata,
    input  logic [WORD_SIZE-1:0]   i_rword,
    output logic [WORD_SIZE/8-1:0] o_wmask,
    output logic [WORD_SIZE-1:0]   o_wdata,
    output logic [WORD_SIZE-1:0]   o_ldata
);

    localparam int unsigned NB = WORD_SIZE / 8;

    logic [4:0]           w_shamt;
    logic [WORD_SIZE-1:0] w_rsh;

    assign w_shamt = {i_byte_off, 3'b000};
    assign w_rsh   = i_rword >> w_shamt;
    assign o_wdata = i_wdata << w_shamt;

    always_comb begin
        o_wmask = '0;
        o_ldata = '0;
        case (i_funct3)
            F3_B: begin
                o_wmask = NB'(1) << i_byte_off;
                o_ldata = {{(WORD_SIZE-8){w_rsh[7]}}, w_rsh[7:0]};
            end
            F3_H: begin
                o_wmask = NB'(3) << i_byte_off;
                o_ldata = {{(WORD_SIZE-16){w_rsh[15]}}, w_rsh[15:0]};
            end
            F3_W: begin
                o_wmask = '1;
                o_ldata = i_rword;
            end
            F3_BU:   o_ldata = {{(WORD_SIZE-8){1'b0}}, w_rsh[7:0]};
            F3_HU:   o_ldata = {{(WORD_SIZE-16){1'b0}}, w_rsh[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder over a word-organised byte-addressable memory.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_we,
    input  logic [2:0]           i_req_funct3,
    input  logic [WORD_SIZE-1:0] i_req_addr,
    input  logic [WORD_SIZE-1:0] i_req_wdata,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [WORD_SIZE-1:0] o_rsp_rdata,
    output logic                 o_rsp_err
);

    localparam int unsigned NB = WORD_SIZE / 8;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic                 r_we;
    logic [2:0]           r_funct3;
    logic [WORD_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0] r_wdata;
    logic [WORD_SIZE-1:0] r_mem [DEPTH];

    logic [AW-1:0]        w_widx;
    logic [WORD_SIZE-1:0] w_rword;
    logic [NB-1:0]        w_wmask;
    logic [WORD_SIZE-1:0] w_wdata_al;
    logic [WORD_SIZE-1:0] w_ldata;
    logic                 w_out_of_range;
    logic                 w_bad_op;
    logic                 w_err;
    logic                 w_fire;
    logic                 w_wr_en;

    assign w_widx         = r_addr[AW+1:2];
    assign w_rword        = r_mem[w_widx];
    assign w_out_of_range = (r_addr >> 2) >= WORD_SIZE'(DEPTH);
    assign w_err          = w_out_of_range || w_bad_op;
    assign w_fire         = (r_state == ST_BUSY) && (r_cnt == '0);
    assign w_wr_en        = w_fire && r_we && !w_err;

    // Illegal size codes and misalignment, split by direction
    always_comb begin
        w_bad_op = 1'b0;
        case (r_funct3)
            F3_B:         w_bad_op = 1'b0;
            F3_H:         w_bad_op = r_addr[0];
            F3_W:         w_bad_op = (r_addr[1:0] != 2'b00);
            F3_BU:        w_bad_op = r_we;
            F3_HU:        w_bad_op = r_we || r_addr[0];
            default:      w_bad_op = 1'b1;
        endcase
    end

    load_store_align #(
        .WORD_SIZE (WORD_SIZE)
    ) u_align (
        .i_funct3   (r_funct3),
        .i_byte_off (r_addr[1:0]),
        .i_wdata    (r_wdata),
        .i_rword    (w_rword),
        .o_wmask    (w_wmask),
        .o_wdata    (w_wdata_al),
        .o_ldata    (w_ldata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_funct3    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_we        <= i_req_we;
                        r_funct3    <= i_req_funct3;
                        r_addr      <= i_req_addr;
                        r_wdata     <= i_req_wdata;
                        r_cnt       <= CW'(LATENCY - 1);
                        o_req_ready <= 1'b0;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= w_err;
                        o_rsp_rdata <= (w_err || r_we) ? '0 : w_ldata;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_rsp_rdata <= '0;
                        o_rsp_err   <= 1'b0;
                        o_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    o_req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Memory has no reset; only a legal store commits, on the BUSY->RESP edge
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (w_wmask[b]) begin
                    r_mem[w_widx][8*b +: 8] <= w_wdata_al[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: loads/stores, extension, errors, backpressure, reset abort.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .WORD_SIZE (32),
        .DEPTH     (256),
        .LATENCY   (2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err)
    );

    // One full request/response; lat = edges from acceptance to rsp_valid, -1 on timeout
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
        bit done;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat   = -1;
        rdata = 32'd0;
        err   = 1'b0;
        done  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (!done) begin
                @(posedge clk);
                #1;
                if (rsp_valid) begin
                    lat   = i;
                    rdata = rsp_rdata;
                    err   = rsp_err;
                    done  = 1'b1;
                end
            end
        end
        if (done) begin
            @(negedge clk);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b err=%b rdata=%h, want 1 0 0 00000000",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er, lat);
        n_tests++;
        if ({lat, rd, er} !== {32'd2, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL sw_0x10: lat=%0d rdata=%h err=%b, want 2 00000000 0", lat, rd, er);
        end
        xact(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        n_tests++;
        if ({lat, rd, er} !== {32'd2, 32'hDEADBEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL lw_0x10: lat=%0d rdata=%h err=%b, want 2 deadbeef 0", lat, rd, er);
        end
    endtask

    task automatic test_extend();
        logic [31:0] rd; logic er; int lat;
        logic [2:0]  f3   [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd0};
        logic [31:0] ad   [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
        logic [31:0] want [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF, 32'hFFFFFFEF};
        for (int i = 0; i < 5; i++) begin
            xact(1'b0, f3[i], ad[i], 32'h0, rd, er, lat);
            n_tests++;
            if ({lat, rd, er} !== {32'd2, want[i], 1'b0}) begin
                n_fail++;
                $display("FAIL load_ext[%0d] f3=%0d addr=%h: lat=%0d rdata=%h err=%b, want 2 %h 0",
                         i, f3[i], ad[i], lat, rd, er, want[i]);
            end
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 3'd0, 32'h11, 32'h00000055, rd, er, lat);
        xact(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        n_tests++;
        if ({rd, er} !== {32'hDEAD55EF, 1'b0}) begin
            n_fail++;
            $display("FAIL sb_then_lw: rdata=%h err=%b, want dead55ef 0", rd, er);
        end
        xact(1'b0, 3'd0, 32'h11, 32'h0, rd, er, lat);
        n_tests++;
        if (rd !== 32'h00000055) begin
            n_fail++;
            $display("FAIL lb_positive: rdata=%h, want 00000055", rd);
        end
        xact(1'b1, 3'd1, 32'h12, 32'h0000A5A5, rd, er, lat);
        xact(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        n_tests++;
        if (rd !== 32'hA5A555EF) begin
            n_fail++;
            $display("FAIL sh_then_lw: rdata=%h, want a5a555ef", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        logic        we   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3   [6] = '{3'd1, 3'd2, 3'd3, 3'd6, 3'd3, 3'd1};
        logic [31:0] ad   [6] = '{32'h11, 32'h12, 32'h0, 32'h0, 32'h0, 32'h3};
        xact(1'b1, 3'd2, 32'h0, 32'hCAFEF00D, rd, er, lat);
        for (int i = 0; i < 6; i++) begin
            xact(we[i], f3[i], ad[i], 32'hFFFFFFFF, rd, er, lat);
            n_tests++;
            if ({lat, rd, er} !== {32'd2, 32'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL err_case[%0d]: lat=%0d rdata=%h err=%b, want 2 00000000 1",
                         i, lat, rd, er);
            end
        end
        xact(1'b1, 3'd2, 32'h400, 32'h11111111, rd, er, lat);
        n_tests++;
        if ({lat, rd, er} !== {32'd2, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL sw_out_of_range: lat=%0d rdata=%h err=%b, want 2 00000000 1", lat, rd, er);
        end
        xact(1'b0, 3'd2, 32'h0, 32'h0, rd, er, lat);
        n_tests++;
        if ({rd, er} !== {32'hCAFEF00D, 1'b0}) begin
            n_fail++;
            $display("FAIL mem_unchanged: rdata=%h err=%b, want cafef00d 0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat;
        int bad;
        bit seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_we = 1'b1; req_wdata = 32'h0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!seen) begin
                @(posedge clk);
                #1;
                seen = rsp_valid;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL bp_rsp_timeout: rsp_valid=%b, want 1", rsp_valid);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if ({rsp_valid, rsp_rdata, rsp_err, req_ready} !== {1'b1, 32'hA5A555EF, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: vld=%b rdata=%h err=%b rdy=%b, want 1 a5a555ef 0 0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
        end
        n_tests++;
        if (bad != 0) n_fail++;
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_tests++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_release: rdy=%b vld=%b rdata=%h err=%b, want 1 0 00000000 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        xact(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        n_tests++;
        if (rd !== 32'hA5A555EF) begin
            n_fail++;
            $display("FAIL bp_store_ignored: rdata=%h, want a5a555ef", rd);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 3'd2, 32'h20, 32'h11112222, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL abort_reset_outputs: rdy=%b vld=%b err=%b rdata=%h, want 1 0 0 00000000",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({req_ready, rsp_valid} !== {1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_reset_held: rdy=%b vld=%b, want 1 0", req_ready, rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        xact(1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat);
        n_tests++;
        if ({lat, rd, er} !== {32'd2, 32'h11112222, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_no_write: lat=%0d rdata=%h err=%b, want 2 11112222 0", lat, rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_extend();
        test_byte_store();
        test_errors();
        test_backpressure();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
